// File: rtl/sram_act_arbiter_pkg.sv
// Shared constants and types for the activation SRAM arbiter.
// Geometry, reader IDs, the read-pipeline record and the address range check.
package act_sram_pkg;

    localparam int CH_NUM       = 24;
    localparam int ACT_PER_ADDR = 4;
    localparam int BW_PER_ACT   = 16;
    localparam int DEPTH        = 58101;
    localparam int AW           = 16;
    localparam int DW           = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;
    localparam int MW           = CH_NUM * ACT_PER_ADDR;

    localparam logic RD_CONV = 1'b0;
    localparam logic RD_SKIP = 1'b1;

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    // Read issued to the SRAM, waiting for its data to be captured next edge.
    typedef struct packed {
        logic vld;
        logic id;
        logic oor;
    } rd_pipe_t;

    function automatic logic addr_in_range(input logic [AW-1:0] addr);
        return (addr < DEPTH_A);
    endfunction

endpackage

// File: rtl/sram_act_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. The winner is exposed before the hold
// so the caller can test it for hazards; the pointer only moves on a grant.
module rr_arb2
    import act_sram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       hold_i,
    output logic       win_vld_o,
    output logic       win_id_o,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    // Pick the winner and gate it with the hold to form the grant.
    always_comb begin
        win_vld_o = |req_i;
        case (req_i)
            2'b01:   win_id_o = RD_CONV;
            2'b10:   win_id_o = RD_SKIP;
            2'b11:   win_id_o = ~last_q;
            default: win_id_o = RD_CONV;
        endcase
        if (win_vld_o && !hold_i) begin
            gnt_o  = win_id_o ? 2'b10 : 2'b01;
            last_d = win_id_o;
        end else begin
            gnt_o  = 2'b00;
            last_d = last_q;
        end
    end

    // Last-granted pointer; resetting to the skip reader favours conv first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= RD_SKIP;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sram_act_arbiter.sv
// Activation SRAM port arbiter: one writer, two round-robin readers,
// same-address hazard blocking, range checking and registered read data.
module sram_act_arbiter
    import act_sram_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [MW-1:0] wr_mask,
    input  logic          rd_valid_0,
    input  logic          rd_valid_1,
    output logic          rd_ready_0,
    output logic          rd_ready_1,
    input  logic [AW-1:0] rd_addr_0,
    input  logic [AW-1:0] rd_addr_1,
    output logic          rd_rvalid_0,
    output logic          rd_rvalid_1,
    output logic [DW-1:0] rd_data,
    input  logic          err_clr,
    output logic          err_oor,
    output logic          sram_csb,
    output logic          sram_wsb,
    output logic [AW-1:0] sram_waddr,
    output logic [AW-1:0] sram_raddr,
    output logic [DW-1:0] sram_wdata,
    output logic [MW-1:0] sram_bytemask,
    input  logic [DW-1:0] sram_rdata
);

    logic [1:0]    rd_gnt_s;
    logic          win_vld_s;
    logic          win_id_s;
    logic [AW-1:0] win_addr_s;
    logic          hazard_s;
    logic          wr_fire_s;
    logic          rd_fire_s;
    logic          wr_oor_s;
    logic          rd_oor_s;
    logic          wr_issue_s;
    logic          rd_issue_s;

    logic          csb_q,   csb_d;
    logic          wsb_q,   wsb_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [MW-1:0] bmask_q, bmask_d;
    rd_pipe_t      pipe_q,  pipe_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q,   err_d;

    assign win_addr_s = win_id_s ? rd_addr_1 : rd_addr_0;
    // Reading an address on the same negedge it is written would return stale data.
    assign hazard_s   = win_vld_s & wr_valid & (wr_addr == win_addr_s);

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     ({rd_valid_1, rd_valid_0}),
        .hold_i    (hazard_s),
        .win_vld_o (win_vld_s),
        .win_id_o  (win_id_s),
        .gnt_o     (rd_gnt_s)
    );

    assign wr_ready   = rst_n;
    assign rd_ready_0 = rd_gnt_s[0];
    assign rd_ready_1 = rd_gnt_s[1];

    assign wr_fire_s  = wr_valid & wr_ready;
    assign rd_fire_s  = |rd_gnt_s;
    assign wr_oor_s   = ~addr_in_range(wr_addr);
    assign rd_oor_s   = ~addr_in_range(win_addr_s);
    assign wr_issue_s = wr_fire_s & ~wr_oor_s;
    assign rd_issue_s = rd_fire_s & ~rd_oor_s;

    // Next-state for SRAM command, read pipeline, read return and error flag.
    always_comb begin
        csb_d    = 1'b1;
        wsb_d    = 1'b1;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        bmask_d  = bmask_q;
        raddr_d  = raddr_q;
        rvalid_d = 2'b00;
        rdata_d  = rdata_q;

        if (wr_issue_s) begin
            wsb_d   = 1'b0;
            waddr_d = wr_addr;
            wdata_d = wr_data;
            bmask_d = wr_mask;
        end else begin
            wsb_d   = 1'b1;
        end

        if (rd_issue_s) begin
            raddr_d = win_addr_s;
        end else begin
            raddr_d = raddr_q;
        end

        if (wr_issue_s || rd_issue_s) begin
            csb_d = 1'b0;
        end else begin
            csb_d = 1'b1;
        end

        pipe_d.vld = rd_fire_s;
        pipe_d.id  = win_id_s;
        pipe_d.oor = rd_oor_s;

        // Out-of-range reads still answer, with zero data.
        if (pipe_q.vld) begin
            rvalid_d = pipe_q.id ? 2'b10 : 2'b01;
            rdata_d  = pipe_q.oor ? {DW{1'b0}} : sram_rdata;
        end else begin
            rvalid_d = 2'b00;
            rdata_d  = rdata_q;
        end

        err_d = (err_q & ~err_clr) | (wr_fire_s & wr_oor_s) | (rd_fire_s & rd_oor_s);
    end

    // State registers; reset drops any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csb_q    <= 1'b1;
            wsb_q    <= 1'b1;
            waddr_q  <= {AW{1'b0}};
            raddr_q  <= {AW{1'b0}};
            wdata_q  <= {DW{1'b0}};
            bmask_q  <= {MW{1'b1}};
            pipe_q   <= '{vld: 1'b0, id: 1'b0, oor: 1'b0};
            rvalid_q <= 2'b00;
            rdata_q  <= {DW{1'b0}};
            err_q    <= 1'b0;
        end else begin
            csb_q    <= csb_d;
            wsb_q    <= wsb_d;
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            wdata_q  <= wdata_d;
            bmask_q  <= bmask_d;
            pipe_q   <= pipe_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign sram_csb      = csb_q;
    assign sram_wsb      = wsb_q;
    assign sram_waddr    = waddr_q;
    assign sram_raddr    = raddr_q;
    assign sram_wdata    = wdata_q;
    assign sram_bytemask = bmask_q;
    assign rd_rvalid_0   = rvalid_q[0];
    assign rd_rvalid_1   = rvalid_q[1];
    assign rd_data       = rdata_q;
    assign err_oor       = err_q;

endmodule

// File: tb/tb_sram_act_arbiter.sv
// Scoreboard bench for sram_act_arbiter with a behavioural negedge SRAM and
// a reference memory that predicts every read return.
module tb_sram_act_arbiter;
    import act_sram_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [MW-1:0] wr_mask = '1;
    logic          rd_valid_0 = 1'b0, rd_valid_1 = 1'b0;
    logic          rd_ready_0, rd_ready_1;
    logic [AW-1:0] rd_addr_0 = '0, rd_addr_1 = '0;
    logic          rd_rvalid_0, rd_rvalid_1;
    logic [DW-1:0] rd_data;
    logic          err_clr = 1'b0;
    logic          err_oor;
    logic          sram_csb, sram_wsb;
    logic [AW-1:0] sram_waddr, sram_raddr;
    logic [DW-1:0] sram_wdata;
    logic [MW-1:0] sram_bytemask;
    logic [DW-1:0] sram_rdata = '0;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] sram_mem[int];
    logic [DW-1:0] ref_mem[int];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;

    sram_act_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_valid_0(rd_valid_0), .rd_valid_1(rd_valid_1),
        .rd_ready_0(rd_ready_0), .rd_ready_1(rd_ready_1),
        .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
        .rd_rvalid_0(rd_rvalid_0), .rd_rvalid_1(rd_rvalid_1),
        .rd_data(rd_data), .err_clr(err_clr), .err_oor(err_oor),
        .sram_csb(sram_csb), .sram_wsb(sram_wsb),
        .sram_waddr(sram_waddr), .sram_raddr(sram_raddr),
        .sram_wdata(sram_wdata), .sram_bytemask(sram_bytemask),
        .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (low 128 bits)", tag, got[127:0], exp[127:0]);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] d,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] v;
        v = old_v;
        for (int i = 0; i < MW; i++) begin
            if (!m[i]) v[i*BW_PER_ACT +: BW_PER_ACT] = d[i*BW_PER_ACT +: BW_PER_ACT];
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (int'(a) >= DEPTH) return '0;
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return '0;
    endfunction

    // Behavioural SRAM: read-before-write on the negedge when selected.
    always @(negedge clk) begin
        if (!sram_csb) begin
            sram_rdata <= sram_mem.exists(int'(sram_raddr)) ? sram_mem[int'(sram_raddr)] : '0;
            if (!sram_wsb) begin
                sram_mem[int'(sram_waddr)] = merge(sram_mem.exists(int'(sram_waddr)) ?
                    sram_mem[int'(sram_waddr)] : '0, sram_wdata, sram_bytemask);
            end
        end
    end

    // Monitor: compare returns against the queue, then record new handshakes.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
        end else begin
            cyc++;
            if (rd_ready_0 && rd_ready_1) check_eq("one_read_per_cycle", DW'(1'b1), DW'(1'b0));
            if (rd_rvalid_0 || rd_rvalid_1) begin
                if (sb.size() == 0) begin
                    check_eq("rvalid_unexpected", DW'(1'b1), DW'(1'b0));
                end else begin
                    e = sb.pop_front();
                    check_eq("rvalid_0", DW'(rd_rvalid_0), DW'(!e.id));
                    check_eq("rvalid_1", DW'(rd_rvalid_1), DW'(e.id));
                    check_eq("rd_data", rd_data, e.data);
                    check_eq("rd_latency", DW'(cyc - e.cyc), DW'(2));
                end
            end else if (sb.size() > 0 && cyc >= sb[0].cyc + 2) begin
                check_eq("rvalid_missing", DW'(1'b0), DW'(1'b1));
                void'(sb.pop_front());
            end
            if (rd_valid_0 && rd_ready_0) sb.push_back('{1'b0, ref_rd(rd_addr_0), cyc});
            if (rd_valid_1 && rd_ready_1) sb.push_back('{1'b1, ref_rd(rd_addr_1), cyc});
            if (wr_valid && wr_ready && int'(wr_addr) < DEPTH) begin
                ref_mem[int'(wr_addr)] = merge(ref_rd(wr_addr), wr_data, wr_mask);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] pat_a5, pat_d, ones_v, half_v;
        pat_a5 = {(DW/8){8'hA5}};
        pat_d  = {(DW/32){32'hDEAD_BEEF}};
        ones_v = '1;
        half_v = {{(DW-16){1'b1}}, 16'h0000};

        repeat (2) tick();
        check_eq("rst_csb", DW'(sram_csb), DW'(1'b1));
        check_eq("rst_wsb", DW'(sram_wsb), DW'(1'b1));
        check_eq("rst_bytemask", DW'(sram_bytemask), DW'({MW{1'b1}}));
        check_eq("rst_rd_data", rd_data, '0);
        check_eq("rst_err", DW'(err_oor), DW'(1'b0));
        rst_n = 1'b1;
        #1;
        check_eq("wr_ready_up", DW'(wr_ready), DW'(1'b1));

        // Reset arriving while a read is in flight.
        tick();
        do_write(16'd9, {(DW/32){32'h1234_5678}}, '0);
        do_write(16'd60000, '0, '0);
        check_eq("err_set_wr", DW'(err_oor), DW'(1'b1));
        rd_valid_0 = 1'b1; rd_addr_0 = 16'd9;
        #1 check_eq("ready_mid", DW'(rd_ready_0), DW'(1'b1));
        tick();
        rd_valid_0 = 1'b0;
        check_eq("issue_csb", DW'(sram_csb), DW'(1'b0));
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_csb", DW'(sram_csb), DW'(1'b1));
        check_eq("midrst_mask", DW'(sram_bytemask), DW'({MW{1'b1}}));
        check_eq("midrst_err", DW'(err_oor), DW'(1'b0));
        tick();
        check_eq("midrst_rvalid", DW'(rd_rvalid_0), DW'(1'b0));
        tick();
        rst_n = 1'b1;

        // Round robin between two always-requesting readers.
        do_write(16'd1, {(DW/32){32'h1111_0001}}, '0);
        do_write(16'd2, {(DW/32){32'h2222_0002}}, '0);
        rd_valid_0 = 1'b1; rd_addr_0 = 16'd1;
        rd_valid_1 = 1'b1; rd_addr_1 = 16'd2;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_eq("rr_ready_0", DW'(rd_ready_0), DW'(i % 2 == 0));
            check_eq("rr_ready_1", DW'(rd_ready_1), DW'(i % 2 == 1));
            tick();
        end
        rd_valid_0 = 1'b0; rd_valid_1 = 1'b0;
        repeat (3) tick();

        // Write then read back.
        do_write(16'd5, pat_a5, '0);
        rd_valid_0 = 1'b1; rd_addr_0 = 16'd5;
        tick();
        rd_valid_0 = 1'b0;
        tick();
        check_eq("wr_rd_rvalid_0", DW'(rd_rvalid_0), DW'(1'b1));
        check_eq("wr_rd_rvalid_1", DW'(rd_rvalid_1), DW'(1'b0));
        check_eq("wr_rd_data", rd_data, pat_a5);

        // Partial mask keeps all but the lowest activation.
        do_write(16'd3, ones_v, '0);
        do_write(16'd3, '0, {{(MW-1){1'b1}}, 1'b0});
        rd_valid_1 = 1'b1; rd_addr_1 = 16'd3;
        tick();
        rd_valid_1 = 1'b0;
        tick();
        check_eq("mask_rvalid", DW'(rd_rvalid_1), DW'(1'b1));
        check_eq("mask_data", rd_data, half_v);

        // Same-address write and read in one cycle.
        do_write(16'd7, {(DW/32){32'h0BAD_0007}}, '0);
        wr_valid = 1'b1; wr_addr = 16'd7; wr_data = pat_d; wr_mask = '0;
        rd_valid_1 = 1'b1; rd_addr_1 = 16'd7;
        #1;
        check_eq("haz_wr_ready", DW'(wr_ready), DW'(1'b1));
        check_eq("haz_rd_ready", DW'(rd_ready_1), DW'(1'b0));
        tick();
        wr_valid = 1'b0;
        #1 check_eq("haz_retry", DW'(rd_ready_1), DW'(1'b1));
        tick();
        rd_valid_1 = 1'b0;
        tick();
        check_eq("haz_data", rd_data, pat_d);

        // Range boundaries.
        do_write(16'd58100, {(DW/32){32'hFACE_58A0}}, '0);
        rd_valid_0 = 1'b1; rd_addr_0 = 16'd58100;
        tick();
        rd_valid_0 = 1'b0;
        check_eq("last_addr_csb", DW'(sram_csb), DW'(1'b0));
        check_eq("last_addr_err", DW'(err_oor), DW'(1'b0));
        tick();
        rd_valid_0 = 1'b1; rd_addr_0 = 16'd58101;
        #1 check_eq("oor_ready", DW'(rd_ready_0), DW'(1'b1));
        tick();
        rd_valid_0 = 1'b0;
        check_eq("oor_csb", DW'(sram_csb), DW'(1'b1));
        check_eq("oor_err", DW'(err_oor), DW'(1'b1));
        tick();
        check_eq("oor_rvalid", DW'(rd_rvalid_0), DW'(1'b1));
        check_eq("oor_data", rd_data, '0);
        wr_valid = 1'b1; wr_addr = 16'd58101; wr_data = ones_v; wr_mask = '0; err_clr = 1'b1;
        tick();
        wr_valid = 1'b0; err_clr = 1'b0;
        check_eq("oor_wr_wsb", DW'(sram_wsb), DW'(1'b1));
        check_eq("clr_vs_new", DW'(err_oor), DW'(1'b1));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("err_clr", DW'(err_oor), DW'(1'b0));

        repeat (4) tick();
        check_eq("sb_drain", DW'(sb.size()), DW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_act_arbiter.md
Name: sram_act_arbiter

Overview:
Shares one activation SRAM between one write requester (layer output writer) and two read requesters (conv operand fetch and residual/skip fetch). The SRAM does one write and one read per clock, both on the negedge.
- Per cycle the block grants at most one write and one read, round-robin between the readers.
- It blocks same-address read/write hazards, rejects out-of-range addresses, and registers read data so it stays stable for requesters.

Parameters:
CH_NUM, 24, channels per SRAM word
ACT_PER_ADDR, 4, activations per channel per word
BW_PER_ACT, 16, bits per activation
DEPTH, 58101, SRAM word count
AW, 16, address width
(derived: DW = CH_NUM*ACT_PER_ADDR*BW_PER_ACT; MW = CH_NUM*ACT_PER_ADDR)

Ports:
clk  in  1  single clock, posedge logic
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  write request
wr_ready  out  1  write accepted this cycle
wr_addr  in  AW  write address
wr_data  in  DW  write data
wr_mask  in  MW  per-activation keep mask (1 = keep old, 0 = write)
rd_valid_0 / rd_valid_1  in  1  read requests
rd_ready_0 / rd_ready_1  out  1  read accepted
rd_addr_0 / rd_addr_1  in  AW  read addresses
rd_rvalid_0 / rd_rvalid_1  out  1  one-cycle data-valid pulse for the owning reader
rd_data  out  DW  registered read data, shared by both readers
err_clr  in  1  clears err_oor
err_oor  out  1  sticky out-of-range flag
sram_csb  out  1  SRAM chip enable, active low
sram_wsb  out  1  SRAM write enable, active low
sram_waddr  out  AW  SRAM write address
sram_raddr  out  AW  SRAM read address
sram_wdata  out  DW  SRAM write data
sram_bytemask  out  MW  SRAM keep mask
sram_rdata  in  DW  SRAM read data (updates on negedge)

Behaviour:
- Reset (asynchronous, any time including mid-read):
  - sram_csb=1, sram_wsb=1; addresses, wdata and rd_data all 0; sram_bytemask all 1.
  - rd_rvalid_* and err_oor = 0; round-robin pointer favours reader 0.
  - An in-flight read is dropped with no rvalid.
- Handshake: a request transfers when valid&ready at a posedge. Ready is combinational from the valids, addresses and arbitration state.
- Write: wr_ready=1 whenever out of reset, so sustained throughput is 1 write per cycle.
- Read arbitration:
  - At most one reader gets ready per cycle.
  - If both are valid, the reader not granted last wins. If one is valid, it wins.
  - The pointer updates only on a completed read handshake.
- Hazard: the winner's rd_ready is forced to 0 when wr_valid=1 and wr_addr equals the winner's rd_addr in the same cycle.
  - Reason: same-negedge read-before-write would return stale data.
  - The write proceeds. The read retries next cycle and the pointer holds.
- Issue: on a handshake at edge E0, SRAM outputs are registered at E0 and held for cycle C1; the SRAM acts at the C1 negedge.
  - sram_csb=0 if any op is issued; sram_wsb=0 only if a write is issued.
  - Idle cycle: csb=1, wsb=1, other outputs hold.
- Read return: at E1 the block registers rd_data<=sram_rdata and pulses rd_rvalid_k for one cycle (C2). Read latency is 2 edges; one read per cycle is sustainable.
- Out of range (addr >= DEPTH):
  - The handshake completes and the SRAM op is suppressed (no csb/wsb for it).
  - err_oor is set at that edge.
  - For a read, rd_rvalid_k still pulses at E1 with rd_data=0.
- err_clr clears err_oor; a new error in the same cycle wins (stays set).

Decomposition:
- Package act_sram_pkg: CH_NUM, ACT_PER_ADDR, BW_PER_ACT, DEPTH, AW, DW, MW, reader-ID constants RD_CONV=0 and RD_SKIP=1.
- Sub-module rr_arb2: 2-input round-robin arbiter with pointer register and a hold input driven by the hazard.

Test Plan:
- Reset mid-read: pulse rst_n low during C1 of a read -> no rd_rvalid, sram_csb=1, sram_bytemask all 1, err_oor=0.
- Write then read: write addr 5, data 0xA5..A5, mask all 0; next cycle reader 0 reads addr 5 -> rd_rvalid_0 high 2 edges after its handshake, rd_data=0xA5..A5, rd_rvalid_1 stays 0.
- Round-robin: both readers valid 6 cycles on addrs 1 and 2 -> grants 0,1,0,1,0,1; rd_data alternates mem[1], mem[2]; one read per cycle.
- Hazard: wr_valid addr 7 new data D with reader 1 addr 7 in the same cycle -> wr_ready=1, rd_ready_1=0; read accepted next cycle and returns D.
- Partial mask: mem[3]=all ones; write 0 with mask bit0=0, other bits 1 -> read gives low 16 bits 0, rest ones.
- Out of range: reader 0 addr 58101 -> sram_csb stays 1, rd_rvalid_0 pulses with rd_data=0, err_oor=1; err_clr -> err_oor=0.
